// File: rtl/enigma_step_ctrl.sv
// rtl/enigma_step_ctrl.sv - keystroke sequencer driving rotor stepping, forward letter and result capture
module enigma_step_ctrl #(
    parameter int NOTCH_R       = 16,
    parameter int NOTCH_M       = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid_in,
    input  logic [4:0]  key_char_in,
    output logic        key_ready_out,
    input  logic [4:0]  pos_r_in,
    input  logic [4:0]  pos_m_in,
    output logic        step_en_r_out,
    output logic        step_en_m_out,
    output logic        step_en_l_out,
    output logic [4:0]  char_fwd_out,
    input  logic [4:0]  enc_char_in,
    output logic        out_valid,
    output logic [4:0]  out_char,
    input  logic        out_ready,
    output logic        err_out,
    output logic [15:0] char_count_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    localparam logic [4:0] NOTCH_R_POS = 5'(NOTCH_R);
    localparam logic [4:0] NOTCH_M_POS = 5'(NOTCH_M);
    localparam logic [4:0] LAST_LETTER = 5'd25;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       key_legal;
    logic       right_at_notch;
    logic       middle_at_notch;

    assign key_ready_out   = (state == IDLE);
    assign key_legal       = (key_char_in <= LAST_LETTER);
    assign right_at_notch  = (pos_r_in == NOTCH_R_POS);
    assign middle_at_notch = (pos_m_in == NOTCH_M_POS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            settle_cnt     <= 4'd0;
            step_en_r_out  <= 1'b0;
            step_en_m_out  <= 1'b0;
            step_en_l_out  <= 1'b0;
            char_fwd_out   <= 5'd0;
            out_valid      <= 1'b0;
            out_char       <= 5'd0;
            err_out        <= 1'b0;
            char_count_out <= 16'd0;
        end else begin
            err_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (key_valid_in) begin
                        if (key_legal) begin
                            char_fwd_out  <= key_char_in;
                            step_en_r_out <= 1'b1;
                            // A middle rotor sitting on its own notch steps itself
                            // and the left rotor: the double step.
                            step_en_m_out <= right_at_notch | middle_at_notch;
                            step_en_l_out <= middle_at_notch;
                            state         <= STEP;
                        end else begin
                            err_out <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    step_en_r_out <= 1'b0;
                    step_en_m_out <= 1'b0;
                    step_en_l_out <= 1'b0;
                    settle_cnt    <= SETTLE_LOAD;
                    state         <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        out_char  <= enc_char_in;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid      <= 1'b0;
                        char_count_out <= char_count_out + 16'd1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
